alux_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared complex-number ALU (`alux`). Two requesters each present an opcode; the arbiter grants one at a time round-robin, issues a one-cycle start to the ALU, waits for `done` or a `maxclock` timeout, captures the 64-bit ALU output, and returns it with a one-cycle acknowledge. It sits between the operation sources (host interface, sequencer) and the single ALU instance.

---
 rtl/alux_arbiter.sv | 146 ++++++++++++++
 tb/tb_alux_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alux_arbiter.sv
// Round-robin two-port arbiter/sequencer for the shared alux ALU; ALUX_ARB_TIMEOUT_EN adds the maxclock timeout.
// Latency: ack 3 cycles after a granted req (immediate done), 1 cycle for illegal opcodes; requesters hold req until their ack.
module alux_arbiter #(
  parameter int DATA_W = 64,
  parameter int OPR_W  = 4,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CNT_W-1:0]  maxclock,
  input  logic              req0,
  input  logic              req1,
  input  logic [OPR_W-1:0]  opr0,
  input  logic [OPR_W-1:0]  opr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              tout,
  output logic              busy,
  output logic              alu_start,
  output logic [OPR_W-1:0]  alu_opr,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [OPR_W-1:0]    opr_q, opr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic                tout_q, tout_d;
  logic                pick;

`ifdef ALUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
  logic                unused_maxclock;
  assign unused_maxclock = ^maxclock;
`endif

  function automatic logic opr_legal(input logic [OPR_W-1:0] op);
    case (op)
      OPR_W'(4'h0), OPR_W'(4'h1), OPR_W'(4'h2), OPR_W'(4'h3), OPR_W'(4'h4),
      OPR_W'(4'h6), OPR_W'(4'h8), OPR_W'(4'h9), OPR_W'(4'hA): opr_legal = 1'b1;
      default: opr_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    opr_d    = opr_q;
    result_d = result_q;
    err_d    = err_q;
    tout_d   = tout_q;
    pick     = 1'b0;
`ifdef ALUX_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        err_d  = 1'b0;
        tout_d = 1'b0;
        if (req0 || req1) begin
          // On a tie the port not served last wins; last_q resets to 1 so port 0 takes the first tie.
          pick    = (req0 && req1) ? ~last_q : req1;
          grant_d = pick;
          last_d  = pick;
          opr_d   = pick ? opr1 : opr0;
          if (opr_legal(opr_d)) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
`ifdef ALUX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          tout_d   = 1'b0;
          state_d  = S_RESP;
        end
`ifdef ALUX_ARB_TIMEOUT_EN
        else if (cnt_q >= maxclock) begin
          result_d = alu_result;
          tout_d   = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      opr_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tout_q   <= 1'b0;
`ifdef ALUX_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      opr_q    <= opr_d;
      result_q <= result_d;
      err_q    <= err_d;
      tout_q   <= tout_d;
`ifdef ALUX_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // err/tout are only meaningful alongside an ack, so they are held low elsewhere.
  assign ack0      = (state_q == S_RESP) && !grant_q;
  assign ack1      = (state_q == S_RESP) &&  grant_q;
  assign err       = (state_q == S_RESP) && err_q;
  assign tout      = (state_q == S_RESP) && tout_q;
  assign busy      = (state_q != S_IDLE);
  assign alu_start = (state_q == S_ISSUE);
  assign alu_opr   = opr_q;
  assign result    = result_q;

endmodule

// File: tb/tb_alux_arbiter.sv
// Bench for alux_arbiter: cycle vector table, hand-written timeout/reset sequences, randomized traffic vs a schedule model.
module tb_alux_arbiter;

  localparam int N    = 700;
  localparam int LAST = 100;
`ifdef ALUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [3:0] LEGAL [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA};
  localparam logic [63:0] R1   = 64'h0000_0005_0000_0003;
  localparam logic [63:0] BASE = 64'hBEEF_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset, req0, req1, alu_done;
  logic [5:0]  maxclock;
  logic [3:0]  opr0, opr1, alu_opr;
  logic [63:0] alu_result, result;
  logic        ack0, ack1, err, tout, busy, alu_start;

  int n_vec = 0;
  int n_err = 0;

  alux_arbiter dut (
    .clock(clock), .reset(reset), .maxclock(maxclock),
    .req0(req0), .req1(req1), .opr0(opr0), .opr1(opr1),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err), .tout(tout),
    .busy(busy), .alu_start(alu_start), .alu_opr(alu_opr),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; alu_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic rst, r0, r1; logic [3:0] o0, o1; logic done; logic [63:0] ares;
    logic a0, a1, bsy, st, er, to; logic [63:0] res; logic oc; logic [3:0] op;
  } vec_t;

  function automatic vec_t mk(logic rst, logic r0, logic r1, logic [3:0] o0, logic [3:0] o1,
                              logic done, logic [63:0] ares, logic a0, logic a1, logic bsy,
                              logic st, logic er, logic to, logic [63:0] res, logic oc, logic [3:0] op);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.o0 = o0; v.o1 = o1; v.done = done; v.ares = ares;
    v.a0 = a0; v.a1 = a1; v.bsy = bsy; v.st = st; v.er = er; v.to = to; v.res = res;
    v.oc = oc; v.op = op;
    return v;
  endfunction

  function automatic logic [63:0] av(int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  task automatic run_table();
    vec_t v [22];
    // single request, done in the first WAIT cycle
    v[0]  = mk(0,1,0,4'h2,4'h0,0,64'd0,  0,0,0,0,0,0,64'd0, 0,4'h0);
    v[1]  = mk(0,1,0,4'h2,4'h0,0,64'd0,  0,0,1,1,0,0,64'd0, 1,4'h2);
    v[2]  = mk(0,1,0,4'h2,4'h0,1,R1,     0,0,1,0,0,0,64'd0, 1,4'h2);
    v[3]  = mk(0,1,0,4'h2,4'h0,0,64'd0,  1,0,1,0,0,0,R1,    0,4'h0);
    v[4]  = mk(0,0,0,4'h0,4'h0,0,64'd0,  0,0,0,0,0,0,R1,    0,4'h0);
    v[5]  = mk(1,0,0,4'h0,4'h0,0,64'd0,  0,0,0,0,0,0,R1,    0,4'h0);
    // contention with done held high throughout (only the WAIT-cycle value is captured)
    v[6]  = mk(0,1,1,4'h3,4'h4,1,av(6),  0,0,0,0,0,0,64'd0, 0,4'h0);
    v[7]  = mk(0,1,1,4'h3,4'h4,1,av(7),  0,0,1,1,0,0,64'd0, 1,4'h3);
    v[8]  = mk(0,1,1,4'h3,4'h4,1,av(8),  0,0,1,0,0,0,64'd0, 1,4'h3);
    v[9]  = mk(0,1,1,4'h3,4'h4,1,av(9),  1,0,1,0,0,0,av(8), 0,4'h0);
    v[10] = mk(0,1,1,4'h3,4'h4,1,av(10), 0,0,0,0,0,0,av(8), 0,4'h0);
    v[11] = mk(0,1,1,4'h3,4'h4,1,av(11), 0,0,1,1,0,0,av(8), 1,4'h4);
    v[12] = mk(0,1,1,4'h3,4'h4,1,av(12), 0,0,1,0,0,0,av(8), 1,4'h4);
    v[13] = mk(0,1,1,4'h3,4'h4,1,av(13), 0,1,1,0,0,0,av(12),0,4'h0);
    v[14] = mk(0,1,1,4'h3,4'h4,1,av(14), 0,0,0,0,0,0,av(12),0,4'h0);
    v[15] = mk(0,1,1,4'h3,4'h4,1,av(15), 0,0,1,1,0,0,av(12),1,4'h3);
    v[16] = mk(0,1,1,4'h3,4'h4,1,av(16), 0,0,1,0,0,0,av(12),1,4'h3);
    v[17] = mk(0,1,1,4'h3,4'h4,1,av(17), 1,0,1,0,0,0,av(16),0,4'h0);
    v[18] = mk(0,0,0,4'h0,4'h0,0,64'd0,  0,0,0,0,0,0,av(16),0,4'h0);
    // illegal opcode on port 1: ack next cycle, no start, result untouched
    v[19] = mk(0,0,1,4'h0,4'h5,0,64'd0,  0,0,0,0,0,0,av(16),0,4'h0);
    v[20] = mk(0,0,1,4'h0,4'h5,1,av(20), 0,1,1,0,1,0,av(16),0,4'h0);
    v[21] = mk(0,0,0,4'h0,4'h0,0,64'd0,  0,0,0,0,0,0,av(16),0,4'h0);
    for (int k = 0; k < 22; k++) begin
      chk1($sformatf("tbl%0d ack0", k), ack0, v[k].a0);
      chk1($sformatf("tbl%0d ack1", k), ack1, v[k].a1);
      chk1($sformatf("tbl%0d busy", k), busy, v[k].bsy);
      chk1($sformatf("tbl%0d alu_start", k), alu_start, v[k].st);
      if (v[k].a0 || v[k].a1) begin
        chk1($sformatf("tbl%0d err", k), err, v[k].er);
        chk1($sformatf("tbl%0d tout", k), tout, v[k].to);
      end
      chk64($sformatf("tbl%0d result", k), result, v[k].res);
      if (v[k].oc) chk64($sformatf("tbl%0d alu_opr", k), 64'(alu_opr), 64'(v[k].op));
      reset = v[k].rst; req0 = v[k].r0; req1 = v[k].r1; opr0 = v[k].o0; opr1 = v[k].o1;
      alu_done = v[k].done; alu_result = v[k].ares;
      tick();
    end
  endtask

  // ---------------- hand-written multi-cycle sequences ----------------
  task automatic run_single(input string tag, input int mc, input int done_at,
                            input int ack_at, input logic exp_tout);
    maxclock = 6'(mc);
    opr0 = 4'h4;
    for (int t = 0; t <= ack_at + 1; t++) begin
      chk1($sformatf("%s ack0 c%0d", tag, t), ack0, t == ack_at);
      chk1($sformatf("%s ack1 c%0d", tag, t), ack1, 1'b0);
      chk1($sformatf("%s start c%0d", tag, t), alu_start, t == 1);
      chk1($sformatf("%s busy c%0d", tag, t), busy, (t >= 1) && (t <= ack_at));
      if (t == ack_at) begin
        chk1($sformatf("%s tout", tag), tout, exp_tout);
        chk1($sformatf("%s err", tag), err, 1'b0);
        chk64($sformatf("%s result", tag), result, BASE + 64'(ack_at - 1));
      end
      req0 = (t <= ack_at);
      alu_done = (t == done_at);
      alu_result = BASE + 64'(t);
      tick();
    end
  endtask

  task automatic run_reset_mid_wait();
    maxclock = 6'd5; opr0 = 4'h2; alu_done = 1'b0;
    req0 = 1'b1;
    tick();
    tick();
    tick();
    chk1("rst_mid busy in WAIT", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; req0 = 1'b0;
    for (int t = 4; t <= 8; t++) begin
      chk1($sformatf("rst_mid ack0 c%0d", t), ack0, 1'b0);
      chk1($sformatf("rst_mid ack1 c%0d", t), ack1, 1'b0);
      chk1($sformatf("rst_mid busy c%0d", t), busy, 1'b0);
      chk1($sformatf("rst_mid start c%0d", t), alu_start, 1'b0);
      chk1($sformatf("rst_mid err c%0d", t), err, 1'b0);
      chk1($sformatf("rst_mid tout c%0d", t), tout, 1'b0);
      chk64($sformatf("rst_mid result c%0d", t), result, 64'd0);
      chk64($sformatf("rst_mid alu_opr c%0d", t), 64'(alu_opr), 64'd0);
      alu_done = (t == 5);
      tick();
    end
  endtask

  // ---------------- randomized traffic vs schedule model ----------------
  bit          m_done [N];
  logic [63:0] m_ares [N];
  bit          m_req0 [N], m_req1 [N];
  logic [3:0]  m_opr0 [N], m_opr1 [N];
  bit          e_ack0 [N], e_ack1 [N], e_busy [N], e_start [N], e_err [N], e_tout [N];
  bit          e_opr_v [N];
  logic [3:0]  e_opr [N];
  logic [63:0] e_res [N];

  function automatic bit is_legal(logic [3:0] op);
    for (int i = 0; i < 9; i++) if (LEGAL[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] rand_opr();
    if ($urandom_range(0, 4) == 0) return 4'($urandom);
    return LEGAL[$urandom_range(0, 8)];
  endfunction

  // An operation granted in cycle t runs to the first cycle w>=t+2 where done is seen
  // (or the budget of mc+1 WAIT cycles is used up); ack lands in w+1 and IDLE returns in w+2.
  task automatic build_random(input int mc);
    int idle_at, last, g, w, a;
    bit act [2];
    int rise_at [2];
    int ack_at [2];
    logic [3:0] cur [2];
    bit cap [N];
    logic [63:0] capv [N];
    logic [63:0] res;
    for (int t = 0; t < N; t++) begin
      m_done[t] = (t >= N - LAST) ? 1'b1 : ($urandom_range(0, 3) == 0);
      m_ares[t] = {$urandom, $urandom};
      e_ack0[t] = 0; e_ack1[t] = 0; e_busy[t] = 0; e_start[t] = 0;
      e_err[t] = 0; e_tout[t] = 0; e_opr_v[t] = 0; e_opr[t] = 4'h0;
      cap[t] = 0; capv[t] = 64'd0;
    end
    idle_at = 0; last = 1;
    act[0] = 0; act[1] = 0; rise_at[0] = 0; rise_at[1] = 1;
    ack_at[0] = -10; ack_at[1] = -10; cur[0] = 4'h0; cur[1] = 4'h0;
    for (int t = 0; t < N; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (act[p] && t == ack_at[p] + 1) begin
          act[p] = 0;
          rise_at[p] = t + 1 + int'($urandom_range(0, 4));
        end
        if (!act[p] && t >= rise_at[p] && t < N - LAST) begin
          act[p] = 1;
          cur[p] = rand_opr();
        end
      end
      m_req0[t] = act[0]; m_req1[t] = act[1];
      m_opr0[t] = act[0] ? cur[0] : 4'($urandom);
      m_opr1[t] = act[1] ? cur[1] : 4'($urandom);
      if (t == idle_at && t < N - 8) begin
        if (!act[0] && !act[1]) begin
          idle_at = t + 1;
        end else begin
          if (act[0] && act[1]) g = 1 - last;
          else g = act[1] ? 1 : 0;
          last = g;
          if (!is_legal(cur[g])) begin
            a = t + 1;
            e_err[a] = 1;
          end else begin
            e_start[t+1] = 1; e_opr_v[t+1] = 1; e_opr[t+1] = cur[g];
            w = t + 2;
            while (!m_done[w] && !(TO_EN && (w - (t + 2)) >= mc)) w++;
            a = w + 1;
            e_tout[a] = !m_done[w];
            cap[a] = 1; capv[a] = m_ares[w];
          end
          for (int k = t + 1; k <= a; k++) e_busy[k] = 1;
          if (g == 0) e_ack0[a] = 1; else e_ack1[a] = 1;
          ack_at[g] = a;
          idle_at = a + 1;
        end
      end
    end
    res = 64'd0;
    for (int t = 0; t < N; t++) begin
      if (cap[t]) res = capv[t];
      e_res[t] = res;
    end
  endtask

  task automatic run_random(input int mc);
    build_random(mc);
    maxclock = 6'(mc);
    do_reset();
    for (int t = 0; t < N; t++) begin
      chk1($sformatf("rnd%0d ack0 c%0d", mc, t), ack0, e_ack0[t]);
      chk1($sformatf("rnd%0d ack1 c%0d", mc, t), ack1, e_ack1[t]);
      chk1($sformatf("rnd%0d busy c%0d", mc, t), busy, e_busy[t]);
      chk1($sformatf("rnd%0d start c%0d", mc, t), alu_start, e_start[t]);
      if (e_ack0[t] || e_ack1[t]) begin
        chk1($sformatf("rnd%0d err c%0d", mc, t), err, e_err[t]);
        chk1($sformatf("rnd%0d tout c%0d", mc, t), tout, e_tout[t]);
      end
      if (e_opr_v[t]) chk64($sformatf("rnd%0d alu_opr c%0d", mc, t), 64'(alu_opr), 64'(e_opr[t]));
      chk64($sformatf("rnd%0d result c%0d", mc, t), result, e_res[t]);
      req0 = m_req0[t]; req1 = m_req1[t]; opr0 = m_opr0[t]; opr1 = m_opr1[t];
      alu_done = m_done[t]; alu_result = m_ares[t];
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; opr0 = 4'h0; opr1 = 4'h0;
    alu_done = 1'b0; alu_result = 64'd0; maxclock = 6'd5;
    do_reset();
    run_table();

    do_reset();
    if (TO_EN) begin
      run_single("timeout5", 5, -1, 8, 1'b1);
      run_single("timeout0", 0, -1, 3, 1'b1);
    end else begin
      run_single("notimeout5", 5, 20, 21, 1'b0);
      run_single("notimeout0", 0, 6, 7, 1'b0);
    end
    run_single("done_and_timeout", 2, 4, 5, 1'b0);
    run_reset_mid_wait();

    run_random(3);
    run_random(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
